button_arbiter: RTL and testbench

//   Shares one command consumer (prime-search control FSM) between N debounced buttons.

---
 rtl/button_pkg.sv | 12 +
 rtl/button_arbiter_if.sv | 11 +
 rtl/button_arbiter_rr_pick.sv | 29 ++
 rtl/button_arbiter.sv | 118 +++++++++++
 tb/tb_button_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared types and defaults for the button arbiter and its command handshake.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int DEFAULT_GAP_CYCLES = 1000;

endpackage

// File: rtl/button_arbiter_if.sv
// Valid/ready command channel from the button arbiter to its single consumer.
interface button_arbiter_if #(
  parameter int ID_W = 2
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [ID_W-1:0] cmd_id;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/button_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N_BTN.
module rr_pick #(
  parameter int N_BTN = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_BTN-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id
);

  int idx;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (req[idx[ID_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/button_arbiter.sv
// Round-robin arbiter sharing one command consumer between N debounced buttons,
// with per-button pending flags, a saturating drop counter and a post-accept gap.
module button_arbiter
  import button_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  pressed_i,
  button_arbiter_if.master  cmd,
  output logic [N_BTN-1:0]  pending_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              busy_o
);

  localparam int ID_W  = $clog2(N_BTN);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [31:0] DROP_MAX = 32'((64'd1 << DROP_W) - 64'd1);

  arb_state_t        state_q, state_d;
  logic [N_BTN-1:0]  pending_q, pending_d;
  logic [N_BTN-1:0]  clear_vec, drop_vec;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              valid_q, busy_q;
  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_id;
  logic [31:0]       drop_sum;

  rr_pick #(
    .N_BTN (N_BTN),
    .ID_W  (ID_W)
  ) u_pick (
    .req       (pending_q),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    gap_d     = gap_q;
    clear_vec = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          id_d              = gnt_id;
          clear_vec[gnt_id] = 1'b1;
          state_d           = OFFER;
        end
      end
      OFFER: begin
        if (cmd.cmd_ready) begin
          ptr_d = (id_q == ID_W'(N_BTN - 1)) ? '0 : id_q + ID_W'(1);
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A press on a bit being granted this cycle re-arms it rather than counting as a drop.
  always_comb begin
    drop_vec  = pressed_i & pending_q & ~clear_vec;
    pending_d = (pending_q & ~clear_vec) | pressed_i;
    drop_sum  = 32'(drop_q);
    for (int k = 0; k < N_BTN; k++) begin
      drop_sum = drop_sum + 32'(drop_vec[k]);
    end
    drop_d = (drop_sum > DROP_MAX) ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      drop_q    <= '0;
      ptr_q     <= '0;
      id_q      <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      gap_q     <= gap_d;
      valid_q   <= (state_d == OFFER);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_id    = id_q;
  assign pending_o     = pending_q;
  assign drop_cnt_o    = drop_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_button_arbiter.sv
// Self-checking bench for button_arbiter: directed vector table, hand sequences and a random run against a reference model.
module tb_button_arbiter;
  import button_pkg::*;

  localparam int N   = 4;
  localparam int GAP = 3;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] pressed;
  logic [3:0] pending;
  logic [7:0] drop_cnt;
  logic       busy;
  logic [2:0] pressed1;
  logic [2:0] pending1;
  logic [1:0] drop1;
  logic       busy1;

  button_arbiter_if #(.ID_W(2)) cmd_if ();
  button_arbiter_if #(.ID_W(2)) cmd_if1 ();

  button_arbiter #(.N_BTN(N), .GAP_CYCLES(GAP), .DROP_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .pressed_i(pressed), .cmd(cmd_if),
    .pending_o(pending), .drop_cnt_o(drop_cnt), .busy_o(busy)
  );

  button_arbiter #(.N_BTN(3), .GAP_CYCLES(GAP), .DROP_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .pressed_i(pressed1), .cmd(cmd_if1),
    .pending_o(pending1), .drop_cnt_o(drop1), .busy_o(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 offering, 2 cooling down for m_wait more cycles.
  int m_mode, m_wait, m_ptr, m_id, m_drops;
  bit m_pend[N];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_mode = 0; m_wait = 0; m_ptr = 0; m_id = 0; m_drops = 0;
    for (int b = 0; b < N; b++) m_pend[b] = 1'b0;
  endtask

  task automatic modelStep(input logic [3:0] p, input logic r);
    bit found;
    int b;
    found = 1'b0;
    case (m_mode)
      0: for (int k = 0; k < N; k++) begin
        b = (m_ptr + k) % N;
        if (!found && m_pend[b]) begin
          found = 1'b1; m_id = b; m_pend[b] = 1'b0; m_mode = 1;
        end
      end
      1: if (r) begin
        m_ptr = (m_id + 1) % N;
        if (GAP == 0) m_mode = 0;
        else begin m_mode = 2; m_wait = GAP; end
      end
      default: begin
        m_wait--;
        if (m_wait == 0) m_mode = 0;
      end
    endcase
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        if (m_pend[i] && m_drops < (1 << DW) - 1) m_drops++;
        m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic compareModel(input int cyc);
    logic [3:0] exp_pend;
    for (int i = 0; i < N; i++) exp_pend[i] = m_pend[i];
    checkOutput($sformatf("rand%0d valid", cyc), 32'(cmd_if.cmd_valid), 32'(m_mode == 1));
    checkOutput($sformatf("rand%0d busy", cyc), 32'(busy), 32'(m_mode != 0));
    checkOutput($sformatf("rand%0d pending", cyc), 32'(pending), 32'(exp_pend));
    checkOutput($sformatf("rand%0d drop", cyc), 32'(drop_cnt), 32'(m_drops));
    if (m_mode == 1) checkOutput($sformatf("rand%0d id", cyc), 32'(cmd_if.cmd_id), 32'(m_id));
  endtask

  task automatic applyStimulus(input logic [3:0] p, input logic r);
    pressed = p;
    cmd_if.cmd_ready = r;
    modelStep(p, r);
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic [2:0] p, input logic r);
    pressed1 = p;
    cmd_if1.cmd_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    pressed = '0;
    pressed1 = '0;
    cmd_if.cmd_ready = 1'b0;
    cmd_if1.cmd_ready = 1'b0;
    modelReset();
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] p;
    logic       r;
    logic       v;
    logic [1:0] id;
    logic [3:0] pend;
    logic       busy;
    logic [7:0] drop;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles[$];
    int ids[$];
    int accepts;
    int valids;

    tbl[0]  = '{4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b0, 8'd0};
    tbl[1]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1, 8'd0};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 8'd0};
    tbl[3]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 8'd0};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 8'd0};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};
    tbl[6]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 8'd0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 8'd0};
    tbl[8]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'd0};
    tbl[9]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'd1};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'd1};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 8'd1};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 8'd1};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 8'd1};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 8'd1};
    tbl[15] = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'd1};
    tbl[16] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0101, 1'b1, 8'd1};
    tbl[17] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0101, 1'b1, 8'd1};
    tbl[18] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0101, 1'b1, 8'd1};
    tbl[19] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0101, 1'b0, 8'd1};
    tbl[20] = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0001, 1'b1, 8'd1};
    tbl[21] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 8'd1};

    doReset();
    checkOutput("reset valid", 32'(cmd_if.cmd_valid), 32'd0);
    checkOutput("reset id", 32'(cmd_if.cmd_id), 32'd0);
    checkOutput("reset pending", 32'(pending), 32'd0);
    checkOutput("reset drop", 32'(drop_cnt), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(tbl[i].p, tbl[i].r);
      checkOutput($sformatf("row%0d valid", i), 32'(cmd_if.cmd_valid), 32'(tbl[i].v));
      checkOutput($sformatf("row%0d pending", i), 32'(pending), 32'(tbl[i].pend));
      checkOutput($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      checkOutput($sformatf("row%0d drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
      if (tbl[i].v) checkOutput($sformatf("row%0d id", i), 32'(cmd_if.cmd_id), 32'(tbl[i].id));
    end

    // All four buttons at once: grants must rotate 0..3, one every five cycles.
    doReset();
    applyStimulus(4'b1111, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (cmd_if.cmd_valid) begin
        cycles.push_back(c);
        ids.push_back(int'(cmd_if.cmd_id));
      end
      applyStimulus(4'b0000, 1'b1);
    end
    checkOutput("rr grant count", 32'(ids.size()), 32'd4);
    for (int k = 0; k < ids.size() && k < 4; k++) begin
      checkOutput($sformatf("rr id%0d", k), 32'(ids[k]), 32'(k));
      if (k > 0) checkOutput($sformatf("rr spacing%0d", k), 32'(cycles[k] - cycles[k-1]), 32'd5);
    end

    // Back-pressure: offer must hold steady until ready, then exactly one accept.
    doReset();
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("bp hold valid%0d", c), 32'(cmd_if.cmd_valid), 32'd1);
      checkOutput($sformatf("bp hold id%0d", c), 32'(cmd_if.cmd_id), 32'd2);
      applyStimulus(4'b0000, 1'b0);
    end
    accepts = 0;
    for (int c = 0; c < 8; c++) begin
      if (cmd_if.cmd_valid) accepts++;
      applyStimulus(4'b0000, 1'b1);
    end
    checkOutput("bp accepts", 32'(accepts), 32'd1);

    // Asynchronous reset while offering discards everything immediately.
    doReset();
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("pre-reset drop", 32'(drop_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async rst valid", 32'(cmd_if.cmd_valid), 32'd0);
    checkOutput("async rst pending", 32'(pending), 32'd0);
    checkOutput("async rst busy", 32'(busy), 32'd0);
    checkOutput("async rst drop", 32'(drop_cnt), 32'd0);
    doReset();
    valids = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b0000, 1'b1);
      if (cmd_if.cmd_valid) valids++;
    end
    checkOutput("post-reset no cmd", 32'(valids), 32'd0);

    // Three-button instance: pointer at 2 with all pending grants 2,0,1 and never id 3.
    doReset();
    step3(3'b010, 1'b1);
    step3(3'b000, 1'b1);
    checkOutput("n3 first id", 32'(cmd_if1.cmd_id), 32'd1);
    step3(3'b111, 1'b1);
    ids.delete();
    for (int c = 0; c < 30; c++) begin
      if (cmd_if1.cmd_valid) begin
        ids.push_back(int'(cmd_if1.cmd_id));
        checkOutput($sformatf("n3 id range c%0d", c), 32'(cmd_if1.cmd_id < 2'd3), 32'd1);
      end
      step3(3'b000, 1'b1);
    end
    checkOutput("n3 grant count", 32'(ids.size()), 32'd3);
    if (ids.size() == 3) begin
      checkOutput("n3 grant0", 32'(ids[0]), 32'd2);
      checkOutput("n3 grant1", 32'(ids[1]), 32'd0);
      checkOutput("n3 grant2", 32'(ids[2]), 32'd1);
    end

    // Two-bit drop counter saturates at 3.
    doReset();
    step3(3'b001, 1'b0);
    step3(3'b000, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step3(3'b001, 1'b0);
      checkOutput($sformatf("sat drop%0d", k), 32'(drop1), 32'((k - 1 > 3) ? 3 : k - 1));
    end

    // Random presses and ready against the reference model.
    doReset();
    for (int c = 0; c < 600; c++) begin
      logic [3:0] p;
      for (int b = 0; b < N; b++) p[b] = ($urandom_range(0, 5) == 0);
      applyStimulus(p, ($urandom_range(0, 2) != 0));
      compareModel(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
